// File: rtl/uart_tx_piso_if.sv
// rtl/uart_tx_piso_if.sv - host load/ready handshake and serial line bundle for uart_tx_piso
interface uart_tx_piso_if;
    logic [7:0] data_in;
    logic       data_load;
    logic       tx_ready;
    logic       tx_out;
    logic       tx_busy;
    logic       tx_done;

    modport master (
        output data_in,
        output data_load,
        input  tx_ready,
        input  tx_out,
        input  tx_busy,
        input  tx_done
    );

    modport slave (
        input  data_in,
        input  data_load,
        output tx_ready,
        output tx_out,
        output tx_busy,
        output tx_done
    );
endinterface

// File: rtl/uart_tx_piso.sv
// rtl/uart_tx_piso.sv - UART transmitter with one-byte holding register and bit-period counter
module uart_tx_piso #(
    parameter int CLKS_PER_BIT = 16,
    parameter int PARITY_EN    = 0,
    parameter int PARITY_ODD   = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic         tx_clk,
    input  logic         reset,
    uart_tx_piso_if.slave tx_if
);

    localparam int             CNT_W     = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic           STOP_LAST = (STOP_BITS == 2) ? 1'b1 : 1'b0;
    localparam logic           ODD_SEL   = (PARITY_ODD != 0) ? 1'b1 : 1'b0;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] baud_cnt;
    logic [2:0]       bit_idx;
    logic             stop_cnt;
    logic [7:0]       shifter;
    logic             parity_bit;
    logic [7:0]       hold_reg;
    logic             hold_full;
    logic             tx_ready_q;
    logic             tx_out_q;
    logic             tx_busy_q;
    logic             tx_done_q;

    logic             baud_end;
    logic             frame_end;
    logic             take;

    assign baud_end  = (baud_cnt == BAUD_LAST);
    assign frame_end = (state == STOP) && baud_end && (stop_cnt == STOP_LAST);
    // The shifter takes the held byte from IDLE or straight out of the last stop bit,
    // which is what keeps back-to-back frames gapless.
    assign take      = hold_full && ((state == IDLE) || frame_end);

    // Frame sequencer, bit-period counter and holding register with registered outputs.
    always_ff @(posedge tx_clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            baud_cnt   <= '0;
            bit_idx    <= 3'd0;
            stop_cnt   <= 1'b0;
            shifter    <= 8'h00;
            parity_bit <= 1'b0;
            hold_reg   <= 8'h00;
            hold_full  <= 1'b0;
            tx_ready_q <= 1'b1;
            tx_out_q   <= 1'b1;
            tx_busy_q  <= 1'b0;
            tx_done_q  <= 1'b0;
        end else begin
            tx_done_q <= 1'b0;

            if (state != IDLE) begin
                baud_cnt <= baud_end ? '0 : baud_cnt + 1'b1;
            end

            case (state)
                IDLE: begin
                    tx_out_q <= 1'b1;
                end
                START: begin
                    if (baud_end) begin
                        state    <= DATA;
                        bit_idx  <= 3'd0;
                        tx_out_q <= shifter[0];
                    end
                end
                DATA: begin
                    if (baud_end) begin
                        shifter <= {1'b0, shifter[7:1]};
                        bit_idx <= bit_idx + 3'd1;
                        if (bit_idx == 3'd7) begin
                            if (PARITY_EN != 0) begin
                                state    <= PARITY;
                                tx_out_q <= parity_bit;
                            end else begin
                                state    <= STOP;
                                stop_cnt <= 1'b0;
                                tx_out_q <= 1'b1;
                            end
                        end else begin
                            tx_out_q <= shifter[1];
                        end
                    end
                end
                PARITY: begin
                    if (baud_end) begin
                        state    <= STOP;
                        stop_cnt <= 1'b0;
                        tx_out_q <= 1'b1;
                    end
                end
                STOP: begin
                    if (baud_end) begin
                        if (stop_cnt == STOP_LAST) begin
                            tx_done_q <= 1'b1;
                            state     <= IDLE;
                            tx_busy_q <= 1'b0;
                            tx_out_q  <= 1'b1;
                        end else begin
                            stop_cnt <= stop_cnt + 1'b1;
                        end
                    end
                end
                default: begin
                    state    <= IDLE;
                    tx_out_q <= 1'b1;
                end
            endcase

            // Start a frame; overrides the STOP->IDLE choice above when a byte is waiting.
            if (take) begin
                shifter    <= hold_reg;
                parity_bit <= (^hold_reg) ^ ODD_SEL;
                hold_full  <= 1'b0;
                tx_ready_q <= 1'b1;
                state      <= START;
                baud_cnt   <= '0;
                tx_out_q   <= 1'b0;
                tx_busy_q  <= 1'b1;
            end

            // Host load; only possible while empty, so it never collides with take.
            if (tx_if.data_load && tx_ready_q) begin
                hold_reg   <= tx_if.data_in;
                hold_full  <= 1'b1;
                tx_ready_q <= 1'b0;
            end
        end
    end

    assign tx_if.tx_ready = tx_ready_q;
    assign tx_if.tx_out   = tx_out_q;
    assign tx_if.tx_busy  = tx_busy_q;
    assign tx_if.tx_done  = tx_done_q;

endmodule

// File: tb/tb_uart_tx_piso.sv
// tb/tb_uart_tx_piso.sv - directed table-driven bench for uart_tx_piso
module tb_uart_tx_piso;

    logic       tx_clk;
    logic       reset;
    logic [7:0] din   [4];
    logic       ld    [4];
    logic       out_w [4];
    logic       rdy_w [4];
    logic       busy_w[4];
    logic       done_w[4];

    int n_cmp;
    int n_err;

    uart_tx_piso_if if0();
    uart_tx_piso_if if1();
    uart_tx_piso_if if2();
    uart_tx_piso_if if3();

    // 0: defaults, 1: even parity, 2: odd parity, 3: two stop bits at 2 clocks/bit
    uart_tx_piso #(.CLKS_PER_BIT(16), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1))
        dut0 (.tx_clk(tx_clk), .reset(reset), .tx_if(if0));
    uart_tx_piso #(.CLKS_PER_BIT(16), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(1))
        dut1 (.tx_clk(tx_clk), .reset(reset), .tx_if(if1));
    uart_tx_piso #(.CLKS_PER_BIT(16), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(1))
        dut2 (.tx_clk(tx_clk), .reset(reset), .tx_if(if2));
    uart_tx_piso #(.CLKS_PER_BIT(2), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(2))
        dut3 (.tx_clk(tx_clk), .reset(reset), .tx_if(if3));

    assign if0.data_in = din[0];
    assign if1.data_in = din[1];
    assign if2.data_in = din[2];
    assign if3.data_in = din[3];
    assign if0.data_load = ld[0];
    assign if1.data_load = ld[1];
    assign if2.data_load = ld[2];
    assign if3.data_load = ld[3];
    assign out_w[0] = if0.tx_out;
    assign out_w[1] = if1.tx_out;
    assign out_w[2] = if2.tx_out;
    assign out_w[3] = if3.tx_out;
    assign rdy_w[0] = if0.tx_ready;
    assign rdy_w[1] = if1.tx_ready;
    assign rdy_w[2] = if2.tx_ready;
    assign rdy_w[3] = if3.tx_ready;
    assign busy_w[0] = if0.tx_busy;
    assign busy_w[1] = if1.tx_busy;
    assign busy_w[2] = if2.tx_busy;
    assign busy_w[3] = if3.tx_busy;
    assign done_w[0] = if0.tx_done;
    assign done_w[1] = if1.tx_done;
    assign done_w[2] = if2.tx_done;
    assign done_w[3] = if3.tx_done;

    initial tx_clk = 1'b0;
    always #5 tx_clk = ~tx_clk;

    typedef struct {
        int          d;
        logic [7:0]  b;
        int          cpb;
        int          nb;
        logic [11:0] pat;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Load one byte into idle DUT d and check every cycle of the frame.
    task automatic run_frame(input int d, input logic [7:0] b, input int cpb,
                             input int nb, input logic [11:0] pat);
        int busy_cnt;
        busy_cnt = 0;
        @(negedge tx_clk);
        din[d] = b;
        ld[d]  = 1'b1;
        @(negedge tx_clk);
        ld[d] = 1'b0;
        chk("ready_low_after_load", rdy_w[d], 0);
        @(negedge tx_clk);
        chk("ready_high_at_start", rdy_w[d], 1);
        for (int t = 0; t < nb * cpb; t++) begin
            chk("frame_bit", out_w[d], pat[t / cpb]);
            chk("done_low_in_frame", done_w[d], 0);
            if (busy_w[d]) busy_cnt++;
            @(negedge tx_clk);
        end
        chk("done_pulse", done_w[d], 1);
        chk("busy_low_after", busy_w[d], 0);
        chk("idle_line", out_w[d], 1);
        chk("busy_cycles", busy_cnt, nb * cpb);
        @(negedge tx_clk);
        chk("done_single_cycle", done_w[d], 0);
    endtask

    initial begin
        logic [9:0] pat_a;
        logic [9:0] pat_b;
        logic       exp_bit;

        n_cmp = 0;
        n_err = 0;
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            din[i] = 8'h00;
            ld[i]  = 1'b0;
        end

        //            d  byte   cpb nb  pattern, bit i = i-th bit on the line
        vecs[0] = '{0, 8'hA5, 16, 10, 12'b0011_0100_1010};
        vecs[1] = '{1, 8'h07, 16, 11, 12'b0110_0000_1110};
        vecs[2] = '{2, 8'h07, 16, 11, 12'b0100_0000_1110};
        vecs[3] = '{3, 8'h80,  2, 11, 12'b0111_0000_0000};
        vecs[4] = '{0, 8'h00, 16, 10, 12'b0010_0000_0000};
        vecs[5] = '{3, 8'h3C,  2, 11, 12'b0110_0111_1000};
        vecs[6] = '{1, 8'h00, 16, 11, 12'b0100_0000_0000};
        vecs[7] = '{2, 8'h00, 16, 11, 12'b0110_0000_0000};

        // Reset state
        repeat (3) @(negedge tx_clk);
        for (int i = 0; i < 4; i++) begin
            chk("rst_tx_out", out_w[i], 1);
            chk("rst_ready", rdy_w[i], 1);
            chk("rst_busy", busy_w[i], 0);
            chk("rst_done", done_w[i], 0);
        end
        reset = 1'b1;
        repeat (2) @(negedge tx_clk);

        // Reset while idle
        #2 reset = 1'b0;
        #1;
        chk("idle_rst_out", out_w[0], 1);
        chk("idle_rst_ready", rdy_w[0], 1);
        @(negedge tx_clk);
        reset = 1'b1;
        repeat (2) @(negedge tx_clk);
        chk("idle_rst_no_done", done_w[0], 0);

        for (int v = 0; v < 8; v++) begin
            run_frame(vecs[v].d, vecs[v].b, vecs[v].cpb, vecs[v].nb, vecs[v].pat);
        end

        // Back-to-back 0x55 then 0x0F; 0xFF offered while full must be dropped
        pat_a = 10'b10_1010_1010;
        pat_b = 10'b10_0001_1110;
        @(negedge tx_clk);
        din[0] = 8'h55;
        ld[0]  = 1'b1;
        @(negedge tx_clk);
        ld[0] = 1'b0;
        @(negedge tx_clk);
        for (int t = 0; t < 320; t++) begin
            exp_bit = (t < 160) ? pat_a[t / 16] : pat_b[(t - 160) / 16];
            chk("b2b_bit", out_w[0], exp_bit);
            chk("b2b_busy", busy_w[0], 1);
            chk("b2b_done", done_w[0], (t == 160) ? 1 : 0);
            if (t == 0)   chk("b2b_ready_t0", rdy_w[0], 1);
            if (t == 100) chk("b2b_ready_full", rdy_w[0], 0);
            if (t == 160) chk("b2b_ready_taken", rdy_w[0], 1);
            if (t == 3)  begin din[0] = 8'h0F; ld[0] = 1'b1; end
            if (t == 4)  begin ld[0] = 1'b0; chk("b2b_ready_low", rdy_w[0], 0); end
            if (t == 10) begin din[0] = 8'hFF; ld[0] = 1'b1; end
            if (t == 13) ld[0] = 1'b0;
            @(negedge tx_clk);
        end
        chk("b2b_done2", done_w[0], 1);
        chk("b2b_busy_end", busy_w[0], 0);
        for (int t = 0; t < 40; t++) begin
            @(negedge tx_clk);
            chk("b2b_no_ff", out_w[0], 1);
            chk("b2b_no_extra_done", done_w[0], 0);
        end

        // Reset during data bit 3 with a second byte held
        @(negedge tx_clk);
        din[0] = 8'hA5;
        ld[0]  = 1'b1;
        @(negedge tx_clk);
        ld[0] = 1'b0;
        @(negedge tx_clk);
        for (int t = 0; t < 70; t++) begin
            if (t == 2) begin din[0] = 8'h3C; ld[0] = 1'b1; end
            if (t == 3) ld[0] = 1'b0;
            @(negedge tx_clk);
        end
        chk("mid_d3_bit", out_w[0], 0);
        chk("mid_held", rdy_w[0], 0);
        #2 reset = 1'b0;
        #1;
        chk("mid_rst_out", out_w[0], 1);
        chk("mid_rst_ready", rdy_w[0], 1);
        chk("mid_rst_busy", busy_w[0], 0);
        chk("mid_rst_done", done_w[0], 0);
        @(negedge tx_clk);
        reset = 1'b1;
        for (int t = 0; t < 400; t++) begin
            @(negedge tx_clk);
            chk("post_rst_out", out_w[0], 1);
            chk("post_rst_done", done_w[0], 0);
            chk("post_rst_busy", busy_w[0], 0);
            chk("post_rst_ready", rdy_w[0], 1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
